// File: rtl/dm_cache_ctrl.sv
// Direct-mapped, write-back, write-allocate cache controller with one word per line.
// It sequences victim write-back and line fill over a req/ack memory port and keeps saturating hit/miss counters.
module dm_cache_ctrl #(
    parameter int IDX_W  = 10,
    parameter int TAG_W  = 10,
    parameter int DATA_W = 32
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   cpu_req,
    input  logic                   cpu_we,
    input  logic [TAG_W+IDX_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0]      cpu_wdata,
    output logic [DATA_W-1:0]      cpu_rdata,
    output logic                   cpu_done,
    output logic                   cpu_hit,
    output logic                   busy,
    output logic                   mem_req,
    output logic                   mem_we,
    output logic [TAG_W+IDX_W-1:0] mem_addr,
    output logic [DATA_W-1:0]      mem_wdata,
    input  logic [DATA_W-1:0]      mem_rdata,
    input  logic                   mem_ack,
    output logic [15:0]            hit_cnt,
    output logic [15:0]            miss_cnt
);

    localparam int ADDR_W = TAG_W + IDX_W;
    localparam int LINES  = 1 << IDX_W;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOOKUP,
        S_WRITEBACK,
        S_FILL,
        S_RESP
    } state_t;

    state_t              state_q, state_d;
    logic                req_we_q, req_we_d;
    logic [ADDR_W-1:0]   req_addr_q, req_addr_d;
    logic [DATA_W-1:0]   req_wdata_q, req_wdata_d;
    logic [LINES-1:0]    valid_q, valid_d;
    logic [LINES-1:0]    dirty_q, dirty_d;
    logic [DATA_W-1:0]   cpu_rdata_q, cpu_rdata_d;
    logic                cpu_done_q, cpu_done_d;
    logic                cpu_hit_q, cpu_hit_d;
    logic                busy_q, busy_d;
    logic                mem_req_q, mem_req_d;
    logic                mem_we_q, mem_we_d;
    logic [ADDR_W-1:0]   mem_addr_q, mem_addr_d;
    logic [DATA_W-1:0]   mem_wdata_q, mem_wdata_d;
    logic [15:0]         hit_cnt_q, hit_cnt_d;
    logic [15:0]         miss_cnt_q, miss_cnt_d;

    logic [TAG_W-1:0]    tag_mem  [LINES];
    logic [DATA_W-1:0]   data_mem [LINES];

    logic                arr_we;
    logic [TAG_W-1:0]    arr_tag;
    logic [DATA_W-1:0]   arr_data;

    logic [IDX_W-1:0]    idx;
    logic [TAG_W-1:0]    req_tag;
    logic [TAG_W-1:0]    line_tag;
    logic [DATA_W-1:0]   line_data;
    logic                lookup_hit;

    assign idx        = req_addr_q[IDX_W-1:0];
    assign req_tag    = req_addr_q[ADDR_W-1:IDX_W];
    assign line_tag   = tag_mem[idx];
    assign line_data  = data_mem[idx];
    assign lookup_hit = valid_q[idx] && (line_tag == req_tag);

    always_comb begin
        state_d     = state_q;
        req_we_d    = req_we_q;
        req_addr_d  = req_addr_q;
        req_wdata_d = req_wdata_q;
        valid_d     = valid_q;
        dirty_d     = dirty_q;
        cpu_rdata_d = cpu_rdata_q;
        cpu_done_d  = 1'b0;
        cpu_hit_d   = 1'b0;
        mem_req_d   = mem_req_q;
        mem_we_d    = mem_we_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        hit_cnt_d   = hit_cnt_q;
        miss_cnt_d  = miss_cnt_q;
        arr_we      = 1'b0;
        arr_tag     = req_tag;
        arr_data    = req_wdata_q;

        unique case (state_q)
            S_IDLE: begin
                if (cpu_req) begin
                    req_we_d    = cpu_we;
                    req_addr_d  = cpu_addr;
                    req_wdata_d = cpu_wdata;
                    state_d     = S_LOOKUP;
                end
            end
            S_LOOKUP: begin
                if (lookup_hit) begin
                    if (req_we_q) begin
                        arr_we       = 1'b1;
                        dirty_d[idx] = 1'b1;
                    end else begin
                        cpu_rdata_d = line_data;
                    end
                    cpu_done_d = 1'b1;
                    cpu_hit_d  = 1'b1;
                    state_d    = S_RESP;
                end else if (valid_q[idx] && dirty_q[idx]) begin
                    mem_req_d   = 1'b1;
                    mem_we_d    = 1'b1;
                    mem_addr_d  = {line_tag, idx};
                    mem_wdata_d = line_data;
                    state_d     = S_WRITEBACK;
                end else if (req_we_q) begin
                    arr_we       = 1'b1;
                    valid_d[idx] = 1'b1;
                    dirty_d[idx] = 1'b1;
                    cpu_done_d   = 1'b1;
                    state_d      = S_RESP;
                end else begin
                    mem_req_d  = 1'b1;
                    mem_we_d   = 1'b0;
                    mem_addr_d = req_addr_q;
                    state_d    = S_FILL;
                end
            end
            S_WRITEBACK: begin
                if (mem_req_q && mem_ack) begin
                    mem_req_d = 1'b0;
                    mem_we_d  = 1'b0;
                    if (req_we_q) begin
                        arr_we       = 1'b1;
                        valid_d[idx] = 1'b1;
                        dirty_d[idx] = 1'b1;
                        cpu_done_d   = 1'b1;
                        state_d      = S_RESP;
                    end else begin
                        state_d = S_FILL;
                    end
                end
            end
            S_FILL: begin
                // Entered with mem_req low after a write-back, giving the one-cycle gap between phases.
                if (mem_req_q && mem_ack) begin
                    mem_req_d    = 1'b0;
                    arr_we       = 1'b1;
                    arr_data     = mem_rdata;
                    valid_d[idx] = 1'b1;
                    dirty_d[idx] = 1'b0;
                    cpu_rdata_d  = mem_rdata;
                    cpu_done_d   = 1'b1;
                    state_d      = S_RESP;
                end else if (!mem_req_q) begin
                    mem_req_d  = 1'b1;
                    mem_we_d   = 1'b0;
                    mem_addr_d = req_addr_q;
                end
            end
            S_RESP: begin
                if (cpu_hit_q) begin
                    hit_cnt_d = (hit_cnt_q == 16'hFFFF) ? hit_cnt_q : hit_cnt_q + 16'd1;
                end else begin
                    miss_cnt_d = (miss_cnt_q == 16'hFFFF) ? miss_cnt_q : miss_cnt_q + 16'd1;
                end
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase

        busy_d = (state_d != S_IDLE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            req_we_q    <= 1'b0;
            req_addr_q  <= '0;
            req_wdata_q <= '0;
            valid_q     <= '0;
            dirty_q     <= '0;
            cpu_rdata_q <= '0;
            cpu_done_q  <= 1'b0;
            cpu_hit_q   <= 1'b0;
            busy_q      <= 1'b0;
            mem_req_q   <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            hit_cnt_q   <= '0;
            miss_cnt_q  <= '0;
        end else begin
            state_q     <= state_d;
            req_we_q    <= req_we_d;
            req_addr_q  <= req_addr_d;
            req_wdata_q <= req_wdata_d;
            valid_q     <= valid_d;
            dirty_q     <= dirty_d;
            cpu_rdata_q <= cpu_rdata_d;
            cpu_done_q  <= cpu_done_d;
            cpu_hit_q   <= cpu_hit_d;
            busy_q      <= busy_d;
            mem_req_q   <= mem_req_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            hit_cnt_q   <= hit_cnt_d;
            miss_cnt_q  <= miss_cnt_d;
        end
    end

    // Tag and data storage is left unreset; the valid bits make stale contents harmless.
    always_ff @(posedge clk) begin
        if (arr_we) begin
            tag_mem[idx]  <= arr_tag;
            data_mem[idx] <= arr_data;
        end
    end

    assign cpu_rdata = cpu_rdata_q;
    assign cpu_done  = cpu_done_q;
    assign cpu_hit   = cpu_hit_q;
    assign busy      = busy_q;
    assign mem_req   = mem_req_q;
    assign mem_we    = mem_we_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;
    assign hit_cnt   = hit_cnt_q;
    assign miss_cnt  = miss_cnt_q;

endmodule

// File: tb/tb_dm_cache_ctrl.sv
// Directed bench for dm_cache_ctrl: a behavioural RAM responder, a bus monitor and one task per scenario.
module tb_dm_cache_ctrl;

    logic        clk;
    logic        rst_n;
    logic        cpu_req;
    logic        cpu_we;
    logic [19:0] cpu_addr;
    logic [31:0] cpu_wdata;
    logic [31:0] cpu_rdata;
    logic        cpu_done;
    logic        cpu_hit;
    logic        busy;
    logic        mem_req;
    logic        mem_we;
    logic [19:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;
    logic        mem_ack;
    logic [15:0] hit_cnt;
    logic [15:0] miss_cnt;

    int errors = 0;
    int checks = 0;

    int cyc = 0;
    int ack_delay = 0;
    int wait_cnt = 0;
    logic [31:0] ram [int];

    int          done_cnt = 0;
    int          done_cyc = 0;
    logic [31:0] done_rdata = '0;
    logic        done_hit = 1'b0;

    int          txn_cnt = 0;
    logic        txn_we        [64];
    logic [19:0] txn_addr      [64];
    logic [31:0] txn_wdata     [64];
    int          txn_start_cyc [64];
    int          txn_ack_cyc   [64];
    int          unstable = 0;

    int drive_cyc = 0;
    int txn0 = 0;

    dm_cache_ctrl dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .cpu_req   (cpu_req),
        .cpu_we    (cpu_we),
        .cpu_addr  (cpu_addr),
        .cpu_wdata (cpu_wdata),
        .cpu_rdata (cpu_rdata),
        .cpu_done  (cpu_done),
        .cpu_hit   (cpu_hit),
        .busy      (busy),
        .mem_req   (mem_req),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata),
        .mem_ack   (mem_ack),
        .hit_cnt   (hit_cnt),
        .miss_cnt  (miss_cnt)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    function automatic logic [31:0] ram_rd(input logic [19:0] a);
        return ram.exists(int'(a)) ? ram[int'(a)] : 32'h0;
    endfunction

    // Memory model: acks after ack_delay request cycles, one-cycle ack pulse.
    initial forever begin
        @(negedge clk);
        mem_ack = 1'b0;
        if (mem_req && rst_n) begin
            if (wait_cnt < ack_delay) begin
                wait_cnt++;
            end else begin
                wait_cnt = 0;
                mem_ack  = 1'b1;
                if (mem_we) ram[int'(mem_addr)] = mem_wdata;
                else        mem_rdata = ram_rd(mem_addr);
            end
        end else begin
            wait_cnt = 0;
        end
    end

    // Bus monitor: logs completions and memory transactions, flags unstable or overlong requests.
    initial begin
        logic        prev_req, prev_ack, s_we;
        logic [19:0] s_addr;
        logic [31:0] s_wdata;
        int          start_cur;
        prev_req = 1'b0; prev_ack = 1'b0; s_we = 1'b0; s_addr = '0; s_wdata = '0; start_cur = 0;
        forever begin
            @(negedge clk);
            #2;
            if (cpu_done) begin
                done_cnt++;
                done_cyc   = cyc;
                done_rdata = cpu_rdata;
                done_hit   = cpu_hit;
            end
            if (mem_req) begin
                if (!prev_req) begin
                    start_cur = cyc;
                    s_we = mem_we; s_addr = mem_addr; s_wdata = mem_wdata;
                end else if (mem_we !== s_we || mem_addr !== s_addr || (s_we && mem_wdata !== s_wdata)) begin
                    unstable++;
                end
                if (prev_ack) unstable++;
                if (mem_ack && txn_cnt < 64) begin
                    txn_we[txn_cnt]        = mem_we;
                    txn_addr[txn_cnt]      = mem_addr;
                    txn_wdata[txn_cnt]     = mem_wdata;
                    txn_start_cyc[txn_cnt] = start_cur;
                    txn_ack_cyc[txn_cnt]   = cyc;
                    txn_cnt++;
                end
            end
            prev_ack = mem_req && mem_ack;
            prev_req = mem_req;
        end
    end

    task automatic step();
        @(negedge clk);
        #3;
    endtask

    task automatic access(input logic we, input logic [19:0] addr, input logic [31:0] wdata);
        int d0;
        int waited;
        d0     = done_cnt;
        waited = 0;
        step();
        cpu_req = 1'b1; cpu_we = we; cpu_addr = addr; cpu_wdata = wdata;
        drive_cyc = cyc;
        txn0      = txn_cnt;
        step();
        cpu_req = 1'b0;
        while (done_cnt == d0 && waited < 60) begin
            step();
            waited++;
        end
        checks++;
        if (done_cnt == d0) begin
            errors++;
            $display("[TB] FAIL access_timeout addr=%05h: no cpu_done within 60 cycles", addr);
        end
        step();
    endtask

    task automatic test_reset();
        rst_n = 1'b1;
        #1 rst_n = 1'b0;
        step(); step();
        checks++; if (busy !== 1'b0)      begin errors++; $display("[TB] FAIL reset_busy: got %0h expected 0", busy); end
        checks++; if (cpu_done !== 1'b0)  begin errors++; $display("[TB] FAIL reset_done: got %0h expected 0", cpu_done); end
        checks++; if (mem_req !== 1'b0)   begin errors++; $display("[TB] FAIL reset_mem_req: got %0h expected 0", mem_req); end
        checks++; if (cpu_rdata !== 32'h0) begin errors++; $display("[TB] FAIL reset_rdata: got %0h expected 0", cpu_rdata); end
        checks++; if (mem_addr !== 20'h0) begin errors++; $display("[TB] FAIL reset_mem_addr: got %0h expected 0", mem_addr); end
        checks++; if (hit_cnt !== 16'h0)  begin errors++; $display("[TB] FAIL reset_hit_cnt: got %0h expected 0", hit_cnt); end
        checks++; if (miss_cnt !== 16'h0) begin errors++; $display("[TB] FAIL reset_miss_cnt: got %0h expected 0", miss_cnt); end
        rst_n = 1'b1;
    endtask

    task automatic test_read_miss_then_hit();
        access(1'b0, 20'h00000, 32'h0);
        checks++; if (done_cyc - drive_cyc !== 3) begin errors++; $display("[TB] FAIL rmiss_latency: got %0d expected 3", done_cyc - drive_cyc); end
        checks++; if (done_rdata !== 32'd9999)    begin errors++; $display("[TB] FAIL rmiss_rdata: got %0d expected 9999", done_rdata); end
        checks++; if (done_hit !== 1'b0)          begin errors++; $display("[TB] FAIL rmiss_hit: got %0h expected 0", done_hit); end
        checks++; if (txn_cnt - txn0 !== 1)       begin errors++; $display("[TB] FAIL rmiss_txns: got %0d expected 1", txn_cnt - txn0); end
        checks++; if (txn_we[txn0] !== 1'b0 || txn_addr[txn0] !== 20'h0)
            begin errors++; $display("[TB] FAIL rmiss_fill: got we=%0h addr=%05h expected we=0 addr=00000", txn_we[txn0], txn_addr[txn0]); end
        checks++; if (miss_cnt !== 16'd1)         begin errors++; $display("[TB] FAIL rmiss_miss_cnt: got %0d expected 1", miss_cnt); end

        access(1'b0, 20'h00000, 32'h0);
        checks++; if (done_cyc - drive_cyc !== 2) begin errors++; $display("[TB] FAIL rhit_latency: got %0d expected 2", done_cyc - drive_cyc); end
        checks++; if (done_rdata !== 32'd9999)    begin errors++; $display("[TB] FAIL rhit_rdata: got %0d expected 9999", done_rdata); end
        checks++; if (done_hit !== 1'b1)          begin errors++; $display("[TB] FAIL rhit_hit: got %0h expected 1", done_hit); end
        checks++; if (txn_cnt - txn0 !== 0)       begin errors++; $display("[TB] FAIL rhit_txns: got %0d expected 0", txn_cnt - txn0); end
        checks++; if (hit_cnt !== 16'd1)          begin errors++; $display("[TB] FAIL rhit_hit_cnt: got %0d expected 1", hit_cnt); end
    endtask

    task automatic test_write_clean_miss();
        access(1'b1, 20'h00002, 32'd7000);
        checks++; if (done_cyc - drive_cyc !== 2) begin errors++; $display("[TB] FAIL wmiss_latency: got %0d expected 2", done_cyc - drive_cyc); end
        checks++; if (done_hit !== 1'b0)          begin errors++; $display("[TB] FAIL wmiss_hit: got %0h expected 0", done_hit); end
        checks++; if (txn_cnt - txn0 !== 0)       begin errors++; $display("[TB] FAIL wmiss_txns: got %0d expected 0", txn_cnt - txn0); end
        checks++; if (miss_cnt !== 16'd2)         begin errors++; $display("[TB] FAIL wmiss_miss_cnt: got %0d expected 2", miss_cnt); end
        access(1'b0, 20'h00002, 32'h0);
        checks++; if (done_rdata !== 32'd7000)    begin errors++; $display("[TB] FAIL wmiss_readback: got %0d expected 7000", done_rdata); end
        checks++; if (done_hit !== 1'b1)          begin errors++; $display("[TB] FAIL wmiss_readback_hit: got %0h expected 1", done_hit); end
        checks++; if (hit_cnt !== 16'd2)          begin errors++; $display("[TB] FAIL wmiss_hit_cnt: got %0d expected 2", hit_cnt); end
    endtask

    task automatic test_dirty_read_miss();
        access(1'b1, 20'h00000, 32'd8000);
        checks++; if (done_hit !== 1'b1)          begin errors++; $display("[TB] FAIL dirty_write_hit: got %0h expected 1", done_hit); end
        access(1'b0, 20'h00400, 32'h0);
        checks++; if (txn_cnt - txn0 !== 2)       begin errors++; $display("[TB] FAIL dirty_txns: got %0d expected 2", txn_cnt - txn0); end
        checks++; if (txn_we[txn0] !== 1'b1 || txn_addr[txn0] !== 20'h00000 || txn_wdata[txn0] !== 32'd8000)
            begin errors++; $display("[TB] FAIL dirty_wb: got we=%0h addr=%05h data=%0d expected we=1 addr=00000 data=8000", txn_we[txn0], txn_addr[txn0], txn_wdata[txn0]); end
        checks++; if (txn_we[txn0+1] !== 1'b0 || txn_addr[txn0+1] !== 20'h00400)
            begin errors++; $display("[TB] FAIL dirty_fill: got we=%0h addr=%05h expected we=0 addr=00400", txn_we[txn0+1], txn_addr[txn0+1]); end
        checks++; if (txn_start_cyc[txn0+1] - txn_ack_cyc[txn0] !== 2)
            begin errors++; $display("[TB] FAIL dirty_gap: got %0d expected 2", txn_start_cyc[txn0+1] - txn_ack_cyc[txn0]); end
        checks++; if (done_cyc - drive_cyc !== 5) begin errors++; $display("[TB] FAIL dirty_latency: got %0d expected 5", done_cyc - drive_cyc); end
        checks++; if (done_rdata !== 32'd1024)    begin errors++; $display("[TB] FAIL dirty_rdata: got %0d expected 1024", done_rdata); end
        checks++; if (done_hit !== 1'b0)          begin errors++; $display("[TB] FAIL dirty_hit: got %0h expected 0", done_hit); end
        // A clean line evicts without write-back, and RAM[0] now holds the written-back word.
        access(1'b0, 20'h00000, 32'h0);
        checks++; if (txn_cnt - txn0 !== 1 || txn_we[txn0] !== 1'b0)
            begin errors++; $display("[TB] FAIL clean_evict: got txns=%0d we=%0h expected txns=1 we=0", txn_cnt - txn0, txn_we[txn0]); end
        checks++; if (done_rdata !== 32'd8000)    begin errors++; $display("[TB] FAIL clean_evict_rdata: got %0d expected 8000", done_rdata); end
        checks++; if (hit_cnt !== 16'd3 || miss_cnt !== 16'd4)
            begin errors++; $display("[TB] FAIL dirty_counters: got hit=%0d miss=%0d expected hit=3 miss=4", hit_cnt, miss_cnt); end
        checks++; if (unstable !== 0)             begin errors++; $display("[TB] FAIL dirty_bus_stable: got %0d expected 0", unstable); end
    endtask

    task automatic test_delayed_ack();
        int  d0, t0, dc;
        bit  got;
        ack_delay = 5;
        d0 = done_cnt; t0 = txn_cnt; got = 0;
        step();
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 20'h00005; dc = cyc;
        for (int i = 0; i < 40 && !got; i++) begin
            step();
            if (i == 3) begin
                checks++; if (busy !== 1'b1) begin errors++; $display("[TB] FAIL delay_busy: got %0h expected 1", busy); end
            end
            if (done_cnt != d0) begin
                got = 1;
                cpu_req = 1'b0;
            end else begin
                cpu_req = ~cpu_req; cpu_we = 1'b1; cpu_addr = 20'h00007;
            end
        end
        cpu_req = 1'b0;
        repeat (5) step();
        checks++; if (done_cnt - d0 !== 1)     begin errors++; $display("[TB] FAIL delay_done_count: got %0d expected 1", done_cnt - d0); end
        checks++; if (txn_cnt - t0 !== 1)      begin errors++; $display("[TB] FAIL delay_txns: got %0d expected 1", txn_cnt - t0); end
        checks++; if (done_rdata !== 32'h55AA) begin errors++; $display("[TB] FAIL delay_rdata: got %0h expected 55aa", done_rdata); end
        checks++; if (done_cyc - dc !== 8)     begin errors++; $display("[TB] FAIL delay_latency: got %0d expected 8", done_cyc - dc); end
        checks++; if (unstable !== 0)          begin errors++; $display("[TB] FAIL delay_bus_stable: got %0d expected 0", unstable); end
        checks++; if (miss_cnt !== 16'd5)      begin errors++; $display("[TB] FAIL delay_miss_cnt: got %0d expected 5", miss_cnt); end
        ack_delay = 0;
    endtask

    task automatic test_reset_mid_fill();
        int d0, t0, w;
        ack_delay = 20;
        d0 = done_cnt; t0 = txn_cnt; w = 0;
        step();
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 20'h00009;
        step();
        cpu_req = 1'b0;
        while (!mem_req && w < 10) begin step(); w++; end
        checks++; if (mem_req !== 1'b1) begin errors++; $display("[TB] FAIL rst_fill_started: got %0h expected 1", mem_req); end
        step(); step();
        rst_n = 1'b0;
        #1;
        checks++; if (mem_req !== 1'b0) begin errors++; $display("[TB] FAIL rst_mem_req_drop: got %0h expected 0", mem_req); end
        checks++; if (busy !== 1'b0)    begin errors++; $display("[TB] FAIL rst_busy_drop: got %0h expected 0", busy); end
        step(); step();
        rst_n = 1'b1;
        ack_delay = 0;
        repeat (5) step();
        checks++; if (done_cnt !== d0 || txn_cnt !== t0)
            begin errors++; $display("[TB] FAIL rst_discard: got dones=%0d txns=%0d expected 0 and 0", done_cnt - d0, txn_cnt - t0); end
        access(1'b0, 20'h00009, 32'h0);
        checks++; if (done_hit !== 1'b0 || txn_cnt - txn0 !== 1)
            begin errors++; $display("[TB] FAIL rst_rereads: got hit=%0h txns=%0d expected hit=0 txns=1", done_hit, txn_cnt - txn0); end
        checks++; if (done_rdata !== 32'h1234) begin errors++; $display("[TB] FAIL rst_reread_data: got %0h expected 1234", done_rdata); end
        checks++; if (miss_cnt !== 16'd1 || hit_cnt !== 16'd0)
            begin errors++; $display("[TB] FAIL rst_counters: got hit=%0d miss=%0d expected hit=0 miss=1", hit_cnt, miss_cnt); end
    endtask

    task automatic test_back_to_back();
        int d0, first, second;
        d0 = done_cnt; first = -1; second = -1;
        step();
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 20'h00009;
        for (int i = 0; i < 20 && second < 0; i++) begin
            step();
            if (done_cnt == d0 + 1 && first < 0) first = done_cyc;
            if (done_cnt == d0 + 2) begin
                second  = done_cyc;
                cpu_req = 1'b0;
            end
        end
        cpu_req = 1'b0;
        repeat (4) step();
        checks++; if (done_cnt - d0 !== 2)  begin errors++; $display("[TB] FAIL b2b_done_count: got %0d expected 2", done_cnt - d0); end
        checks++; if (second - first !== 3) begin errors++; $display("[TB] FAIL b2b_spacing: got %0d expected 3", second - first); end
        checks++; if (hit_cnt !== 16'd2)    begin errors++; $display("[TB] FAIL b2b_hit_cnt: got %0d expected 2", hit_cnt); end
    endtask

    task automatic test_saturation();
        step();
        force dut.hit_cnt_q = 16'hFFFE;
        #1;
        release dut.hit_cnt_q;
        access(1'b0, 20'h00009, 32'h0);
        checks++; if (done_hit !== 1'b1)     begin errors++; $display("[TB] FAIL sat_hit: got %0h expected 1", done_hit); end
        checks++; if (hit_cnt !== 16'hFFFF)  begin errors++; $display("[TB] FAIL sat_first: got %0h expected ffff", hit_cnt); end
        access(1'b0, 20'h00009, 32'h0);
        checks++; if (hit_cnt !== 16'hFFFF)  begin errors++; $display("[TB] FAIL sat_hold: got %0h expected ffff", hit_cnt); end
        checks++; if (miss_cnt !== 16'd1)    begin errors++; $display("[TB] FAIL sat_miss_cnt: got %0d expected 1", miss_cnt); end
    endtask

    initial begin
        cpu_req = 1'b0; cpu_we = 1'b0; cpu_addr = '0; cpu_wdata = '0;
        mem_ack = 1'b0; mem_rdata = '0;
        ram[32'h00000] = 32'd9999;
        ram[32'h00400] = 32'd1024;
        ram[32'h00005] = 32'h55AA;
        ram[32'h00009] = 32'h1234;
        test_reset();
        test_read_miss_then_hit();
        test_write_clean_miss();
        test_dirty_read_miss();
        test_delayed_ack();
        test_reset_mid_fill();
        test_back_to_back();
        test_saturation();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
